gray_binario_serial: RTL and testbench

Sequential Gray-to-binary decoder. It is the inverse of the team's combinational binary-to-Gray encoder. It accepts one WIDTH-bit Gray code through a valid/ready handshake and resolves one bit per clock, MSB first, using b[i] = b[i+1] ^ g[i]. The registered binary result is presented through a valid/ready handshake. It sits between Gray-coded sources (position encoders, CDC Gray pointers) and binary consumers, and trades latency for a single XOR stage.

---
 rtl/gray_binario_serial_if.sv | 36 +++
 rtl/gray_binario_serial.sv | 125 ++++++++++++
 tb/tb_gray_binario_serial.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_binario_serial_if.sv
// Handshake bundle for the serial Gray-to-binary decoder: code input, result output, status.
// With GRAY_STEP_CHECK_EN defined the bundle also carries the step_err flag.
interface gray_binario_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] binario;
    logic             busy;
`ifdef GRAY_STEP_CHECK_EN
    logic             step_err;

    modport master (
        output in_valid, gray, out_ready,
        input  in_ready, out_valid, binario, busy, step_err
    );

    modport slave (
        input  in_valid, gray, out_ready,
        output in_ready, out_valid, binario, busy, step_err
    );
`else
    modport master (
        output in_valid, gray, out_ready,
        input  in_ready, out_valid, binario, busy
    );

    modport slave (
        input  in_valid, gray, out_ready,
        output in_ready, out_valid, binario, busy
    );
`endif
endinterface

// File: rtl/gray_binario_serial.sv
// Serial Gray-to-binary decoder: one bit per clock, MSB first, valid/ready on both sides.
// Optional macro GRAY_STEP_CHECK_EN adds step_err, flagging accepted codes that are not a unit Gray step.
module gray_binario_serial #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    gray_binario_serial_if.slave    bus
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] bin_step;
    logic [IW-1:0]    idx_q, idx_d;
    logic             accept;

    assign bus.in_ready  = (state_q == IDLE) & ~rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == CONV);
    assign bus.binario   = bin_q;
    assign accept        = bus.in_valid & bus.in_ready;

    // Only the bit selected by idx_q is resolved this cycle; it uses the bit above,
    // which was resolved on the previous edge (the MSB has an implicit zero above it).
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            localparam logic [IW-1:0] BIT_IDX = IW'(gi);
            logic upper;
            if (gi == WIDTH - 1) begin : g_msb
                assign upper = 1'b0;
            end else begin : g_lower
                assign upper = bin_q[gi+1];
            end
            assign bin_step[gi] = (idx_q == BIT_IDX) ? (upper ^ g_q[gi]) : bin_q[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        bin_d   = bin_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    g_d     = bus.gray;
                    idx_d   = IW'(WIDTH - 1);
                    state_d = CONV;
                end
            end
            CONV: begin
                bin_d = bin_step;
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            bin_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            bin_q   <= bin_d;
            idx_q   <= idx_d;
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic             step_err_q, step_err_d;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             have_prev_q, have_prev_d;

    // A legal Gray sequence changes exactly one bit; a repeated code is also an error.
    always_comb begin
        step_err_d  = step_err_q;
        prev_gray_d = prev_gray_q;
        have_prev_d = have_prev_q;
        if (accept) begin
            step_err_d  = have_prev_q & ($countones(bus.gray ^ prev_gray_q) != 1);
            prev_gray_d = bus.gray;
            have_prev_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_err_q  <= 1'b0;
            prev_gray_q <= '0;
            have_prev_q <= 1'b0;
        end else begin
            step_err_q  <= step_err_d;
            prev_gray_q <= prev_gray_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign bus.step_err = step_err_q;
`endif

endmodule

// File: tb/tb_gray_binario_serial.sv
// Directed bench for gray_binario_serial: WIDTH=8 and WIDTH=1 instances driven from one initial block.
module tb_gray_binario_serial;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    gray_binario_serial_if #(.WIDTH(8)) b8 ();
    gray_binario_serial_if #(.WIDTH(1)) b1 ();

    gray_binario_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    gray_binario_serial #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decoder: search for the binary whose Gray encoding is g.
    function automatic logic [7:0] g2b_model(input logic [7:0] g);
        logic [7:0] bb;
        for (int b = 0; b < 256; b++) begin
            bb = 8'(b);
            if ((bb ^ (bb >> 1)) == g) return bb;
        end
        return 8'h00;
    endfunction

    task automatic wait_ready8(input string tag);
        int n = 0;
        while (!b8.in_ready && n < 30) begin
            step();
            n++;
        end
        if (!b8.in_ready) chk({tag, "_ready_timeout"}, 32'(b8.in_ready), 32'd1);
    endtask

    task automatic wait_valid8(input string tag);
        int n = 0;
        while (!b8.out_valid && n < 30) begin
            step();
            n++;
        end
        if (!b8.out_valid) chk({tag, "_valid_timeout"}, 32'(b8.out_valid), 32'd1);
    endtask

    // Full conversion on the 8-bit instance, checking latency, busy span and result.
    task automatic conv8(input logic [7:0] g, input logic [7:0] exp, input string tag);
        int n = 0;
        int busy_n = 0;
        wait_ready8(tag);
        b8.gray     = g;
        b8.in_valid = 1'b1;
        step();
        b8.in_valid = 1'b0;
        b8.gray     = ~g;
        chk({tag, "_in_ready_low"}, 32'(b8.in_ready), 32'd0);
        while (!b8.out_valid && n < 20) begin
            if (b8.busy) busy_n++;
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        chk({tag, "_binario"}, 32'(b8.binario), 32'(exp));
        $display("txn %s gray=0x%02h binario=0x%02h latency=%0d", tag, g, b8.binario, n);
        b8.out_ready = 1'b1;
        step();
        b8.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(b8.out_valid), 32'd0);
    endtask

    initial begin
        int t;
        int prev_t;
        int n;
        b8.in_valid = 1'b0; b8.gray = 8'h00; b8.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.gray = 1'b0;  b1.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk("rst_binario", 32'(b8.binario), 32'h0);
        chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
        chk("rst_busy", 32'(b8.busy), 32'd0);
        chk("rst_in_ready", 32'(b8.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(b8.in_ready), 32'd1);

        // Basic codes
        conv8(8'h00, 8'h00, "g00");
        conv8(8'hFF, 8'hAA, "gFF");
        conv8(8'h80, 8'hFF, "g80");

        // Exhaustive sweep, streaming with out_ready held high
        b8.out_ready = 1'b1;
        b8.in_valid  = 1'b1;
        prev_t = 0;
        for (int c = 0; c < 256; c++) begin
            n = 0;
            while (!b8.in_ready && n < 30) begin
                step();
                n++;
            end
            if (!b8.in_ready) chk("sweep_ready_timeout", 32'(b8.in_ready), 32'd1);
            b8.gray = 8'(c);
            t = cyc;
            step();
            b8.gray = ~8'(c);
            wait_valid8("sweep");
            chk("sweep_binario", 32'(b8.binario), 32'(g2b_model(8'(c))));
            if (c > 0) chk("sweep_spacing", 32'(t - prev_t), 32'd10);
            prev_t = t;
        end
        b8.in_valid = 1'b0;
        step();
        b8.out_ready = 1'b0;
        $display("txn sweep codes=256 done");

        // Backpressure
        wait_ready8("bp");
        b8.gray = 8'h4C;
        b8.in_valid = 1'b1;
        step();
        b8.in_valid = 1'b0;
        wait_valid8("bp");
        chk("bp_binario", 32'(b8.binario), 32'h77);
        b8.in_valid = 1'b1;
        b8.gray = 8'h01;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_valid", 32'(b8.out_valid), 32'd1);
            chk("bp_hold_binario", 32'(b8.binario), 32'h77);
            chk("bp_hold_in_ready", 32'(b8.in_ready), 32'd0);
            chk("bp_hold_busy", 32'(b8.busy), 32'd0);
        end
        b8.out_ready = 1'b1;
        step();
        b8.out_ready = 1'b0;
        chk("bp_release_valid", 32'(b8.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(b8.in_ready), 32'd1);
        chk("bp_release_retain", 32'(b8.binario), 32'h77);
        step();
        b8.in_valid = 1'b0;
        chk("bp_next_busy", 32'(b8.busy), 32'd1);
        wait_valid8("bp_next");
        chk("bp_next_binario", 32'(b8.binario), 32'h01);
        $display("txn backpressure gray=0x4c then 0x01 binario=0x%02h", b8.binario);
        b8.out_ready = 1'b1;
        step();
        b8.out_ready = 1'b0;

        // Reset in the third CONV cycle
        wait_ready8("rstmid");
        b8.gray = 8'hFF;
        b8.in_valid = 1'b1;
        step();
        b8.in_valid = 1'b0;
        step();
        step();
        chk("rstmid_busy_before", 32'(b8.busy), 32'd1);
        rst = 1'b1;
        step();
        chk("rstmid_binario", 32'(b8.binario), 32'h0);
        chk("rstmid_busy", 32'(b8.busy), 32'd0);
        chk("rstmid_out_valid", 32'(b8.out_valid), 32'd0);
        chk("rstmid_in_ready_in_rst", 32'(b8.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstmid_in_ready", 32'(b8.in_ready), 32'd1);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (b8.out_valid) n++;
        end
        chk("rstmid_no_valid", 32'(n), 32'd0);
        $display("txn reset_mid_conversion discarded");

        // WIDTH=1 instance
        chk("w1_ready", 32'(b1.in_ready), 32'd1);
        b1.gray = 1'b1;
        b1.in_valid = 1'b1;
        step();
        b1.in_valid = 1'b0;
        chk("w1a_busy", 32'(b1.busy), 32'd1);
        chk("w1a_valid_early", 32'(b1.out_valid), 32'd0);
        step();
        chk("w1a_valid", 32'(b1.out_valid), 32'd1);
        chk("w1a_binario", 32'(b1.binario), 32'd1);
        $display("txn w1 gray=1 binario=%0d", b1.binario);
        b1.out_ready = 1'b1;
        step();
        b1.out_ready = 1'b0;
        chk("w1b_ready", 32'(b1.in_ready), 32'd1);
        b1.gray = 1'b0;
        b1.in_valid = 1'b1;
        step();
        b1.in_valid = 1'b0;
        step();
        chk("w1b_valid", 32'(b1.out_valid), 32'd1);
        chk("w1b_binario", 32'(b1.binario), 32'd0);
        $display("txn w1 gray=0 binario=%0d", b1.binario);
        b1.out_ready = 1'b1;
        step();
        b1.out_ready = 1'b0;

`ifdef GRAY_STEP_CHECK_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("se_rst", 32'(b8.step_err), 32'd0);
        conv8(8'h00, 8'h00, "se00");
        chk("se_first", 32'(b8.step_err), 32'd0);
        conv8(8'h01, 8'h01, "se01");
        chk("se_01", 32'(b8.step_err), 32'd0);
        conv8(8'h03, 8'h02, "se03");
        chk("se_03", 32'(b8.step_err), 32'd0);
        conv8(8'h00, 8'h00, "se00b");
        chk("se_jump", 32'(b8.step_err), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("se_rst2", 32'(b8.step_err), 32'd0);
        conv8(8'h55, 8'h66, "se55");
        chk("se_after_rst", 32'(b8.step_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
